// File: rtl/multiword_adder_seq_if.sv
// rtl/multiword_adder_seq_if.sv - request/result handshake bundle for the slice-serial wide adder
interface multiword_adder_seq_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    modport master (
        output in_valid, A, B, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, A, B, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/multiword_adder_seq.sv
// rtl/multiword_adder_seq.sv - W-bit adder built by streaming N-bit slices through one N_bit_adder
module N_bit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module multiword_adder_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multiword_adder_seq_if.slave bus
);
    localparam int W     = N * WORDS;
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     result;
    logic             carry;
    logic             c_out_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     slice_sum;
    logic             slice_c_out;
    logic             last_slice;
    logic             in_ready;
    logic             out_valid;

    N_bit_adder #(.N(N)) u_slice_adder (
        .a     (a_sh[N-1:0]),
        .b     (b_sh[N-1:0]),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c_out)
    );

    assign last_slice = (cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = RUN;
            end
            RUN: begin
                if (last_slice) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operands shift right so the active slice is always at bits [N-1:0];
    // on the last slice those bits hold the operand sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            result  <= '0;
            carry   <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> N;
                    b_sh   <= b_sh >> N;
                    result <= {slice_sum, result[W-1:N]};
                    carry  <= slice_c_out;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_slice) begin
                        c_out_q <= slice_c_out;
                        ovf_q   <= (a_sh[N-1] == b_sh[N-1]) && (slice_sum[N-1] != a_sh[N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = result;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb/tb_multiword_adder_seq.sv - randomized bench for multiword_adder_seq in two slice geometries
module tb_multiword_adder_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multiword_adder_seq_if #(.N(8), .WORDS(4)) i8 ();
    multiword_adder_seq_if #(.N(4), .WORDS(3)) i4 ();

    multiword_adder_seq #(.N(8), .WORDS(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    multiword_adder_seq #(.N(4), .WORDS(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain (W+1)-bit unsigned sum and signed range test.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin, input int w,
                         output logic [31:0] s, output logic co, output logic ov);
        longint unsigned mask, tot;
        longint sa, sb, ss, half;
        mask = (64'd1 << w) - 64'd1;
        half = longint'(1) << (w - 1);
        tot  = (a & mask) + (b & mask) + longint'(cin);
        s    = 32'(tot & mask);
        co   = tot[w];
        sa   = longint'(a & mask);
        sb   = longint'(b & mask);
        if (sa >= half) sa -= 2 * half;
        if (sb >= half) sb -= 2 * half;
        ss = sa + sb + longint'(cin);
        ov = (ss >= half) || (ss < -half);
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic ordy);
        if (sel) begin
            i4.in_valid = v; i4.A = a[11:0]; i4.B = b[11:0]; i4.c_in = cin; i4.out_ready = ordy;
        end else begin
            i8.in_valid = v; i8.A = a; i8.B = b; i8.c_in = cin; i8.out_ready = ordy;
        end
    endtask

    task automatic sample(input bit sel, output logic ir, output logic ov, output logic [31:0] s,
                          output logic co, output logic of);
        if (sel) begin
            ir = i4.in_ready; ov = i4.out_valid; s = {20'd0, i4.sum}; co = i4.c_out; of = i4.overflow;
        end else begin
            ir = i8.in_ready; ov = i8.out_valid; s = i8.sum; co = i8.c_out; of = i8.overflow;
        end
    endtask

    task automatic junk(input bit sel);
        drive(sel, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
    endtask

    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int gap);
        int words, w, k;
        logic [31:0] es, s, s0;
        logic eco, eof, ir, ov, co, of, co0, of0;
        words = sel ? 3 : 4;
        w     = sel ? 12 : 32;
        model(a, b, cin, w, es, eco, eof);
        @(negedge clk);
        sample(sel, ir, ov, s, co, of);
        check("idle_handshake", {62'd0, ir, ov}, 64'b10);
        drive(sel, 1'b1, a, b, cin, 1'b0);
        @(negedge clk);
        junk(sel);
        sample(sel, ir, ov, s, co, of);
        k = 0;
        while (!ov && k < 20) begin
            @(negedge clk);
            junk(sel);
            sample(sel, ir, ov, s, co, of);
            k++;
        end
        check("latency", 64'(k), 64'(words));
        check("sum", {32'd0, s}, {32'd0, es});
        check("c_out", {63'd0, co}, {63'd0, eco});
        check("overflow", {63'd0, of}, {63'd0, eof});
        s0 = s; co0 = co; of0 = of;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            junk(sel);
            sample(sel, ir, ov, s, co, of);
            check("hold", {28'd0, ov, ir, co, of, s}, {28'd0, 1'b1, 1'b0, co0, of0, s0});
        end
        drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        sample(sel, ir, ov, s, co, of);
        check("release", {62'd0, ir, ov}, 64'b10);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_07FF;
            5:       return 32'h0000_0800;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] da [7];
        logic [31:0] db [7];
        logic        dc [7];
        logic [31:0] s;
        logic        ir, ov, co, of;
        da = '{32'd5, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd30, 32'h1234_5678};
        db = '{32'd3, 32'd1,         32'd0,         32'd1,         32'h8000_0000, 32'hFFFF_FFF6, 32'h0FED_CBA9};
        dc = '{1'b0,  1'b0,          1'b1,          1'b0,          1'b0,          1'b0,  1'b1};

        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            sample(sel[0], ir, ov, s, co, of);
            check("reset_state", {28'd0, ir, ov, co, of, s}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        end
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(0, da[i], db[i], dc[i], (i == 6) ? 5 : 0);

        @(negedge clk);
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(0, ir, ov, s, co, of);
        check("reset_mid_run", {28'd0, ir, ov, co, of, s}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        drive(0, 1'b1, 32'h5555_5555, 32'h1111_1111, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            sample(0, ir, ov, s, co, of);
            check("no_stale_result", {62'd0, ir, ov}, 64'b10);
        end
        run_op(0, 32'd127, 32'd1, 1'b0, 0);

        for (int i = 0; i < 500; i++)
            run_op(0, rnd_op(), rnd_op(), 1'($urandom), int'($urandom_range(0, 3)));
        for (int i = 0; i < 300; i++)
            run_op(1, rnd_op(), rnd_op(), 1'($urandom), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
